// File: rtl/imem_loader.sv
// Boot loader: streams a little-endian word-count header plus payload bytes into the
// instruction-memory write port, holding the core in reset. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned IMEM_DEPTH = 512
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             byteValid,
  input  logic [7:0]       byteData,
  output logic             byteReady,
  output logic             insMemEn,
  output logic [WIDTH-1:0] insMemAddr,
  output logic [WIDTH-1:0] insMemDataIn,
  output logic             cpuReset,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DRAIN,
    S_RUN,
    S_ERR
  } state_e;

  // State entered once the payload (possibly empty) has been fully received
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_PAYLOAD_END = S_CHK;
`else
  localparam state_e S_PAYLOAD_END = S_DRAIN;
`endif

  state_e           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             en_q, en_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic             accept;
  logic [WIDTH-1:0] word;

  assign byteReady = (state_q == S_HDR) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state_q == S_CHK)
`endif
                     ;
  assign accept = byteValid && byteReady;
  // First byte lands in bits [7:0] after four shifts
  assign word   = {byteData, shift_q[WIDTH-1:8]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_HDR;
      lane_q    <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_HDR: begin
        if (accept) begin
          shift_d = word;
          lane_d  = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            cnt_d = word;
            k_d   = '0;
            if (word > WIDTH'(IMEM_DEPTH)) begin
              state_d = S_ERR;
            end else if (word == '0) begin
              state_d = S_PAYLOAD_END;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d = word;
          lane_d  = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ byteData;
`endif
          if (lane_q == 2'd3) begin
            en_d   = 1'b1;
            addr_d = k_q;
            data_d = word;
            k_d    = k_q + WIDTH'(1);
            if (k_q == cnt_q - WIDTH'(1)) begin
              state_d = S_PAYLOAD_END;
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (byteData == csum_q) ? S_DRAIN : S_ERR;
        end
      end
`endif
      // One cycle so the final write lands before the core leaves reset
      S_DRAIN: state_d = S_RUN;
      default: ;
    endcase
    cpu_rst_d = (state_d != S_RUN);
    done_d    = (state_d == S_RUN);
    err_d     = (state_d == S_ERR);
  end

  assign insMemEn     = en_q;
  assign insMemAddr   = addr_q;
  assign insMemDataIn = data_q;
  assign cpuReset     = cpu_rst_q;
  assign done         = done_q;
  assign error        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus and
// checked by a monitor on the falling edge; status outputs are checked at fixed offsets.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        byteValid;
  logic [7:0]  byteData;
  logic        byteReady;
  logic        insMemEn;
  logic [31:0] insMemAddr;
  logic [31:0] insMemDataIn;
  logic        cpuReset;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  imem_loader #(.WIDTH(32), .IMEM_DEPTH(512)) dut (
    .clock        (clock),
    .reset        (reset),
    .byteValid    (byteValid),
    .byteData     (byteData),
    .byteReady    (byteReady),
    .insMemEn     (insMemEn),
    .insMemAddr   (insMemAddr),
    .insMemDataIn (insMemDataIn),
    .cpuReset     (cpuReset),
    .done         (done),
    .error        (error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Every write strobe must match the oldest outstanding expected write
  task automatic monitor;
    wr_t e;
    forever begin
      @(negedge clock);
      if (insMemEn === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("write_expected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", insMemAddr, e.addr);
          check("wr_data", insMemDataIn, e.data);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    byteValid = 1'b1;
    byteData  = b;
    @(posedge clock);
    #1;
    byteValid = 1'b0;
    byteData  = 8'hEE;
  endtask

  task automatic idle_gap;
    int g;
    g = $urandom_range(0, 3);
    repeat (g) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int j = 0; j < 4; j++) begin
      if (gaps) idle_gap();
      send(w[8*j +: 8]);
    end
  endtask

  // Header, payload words from img, and (when compiled in) the XOR checksum byte
  task automatic load_img(input bit gaps, input bit bad_csum);
    logic [31:0] n;
    logic [7:0]  cs;
    n  = 32'(img.size());
    cs = 8'h00;
    send_word(n, gaps);
    for (int i = 0; i < img.size(); i++) begin
      push_exp(32'(i), img[i]);
      for (int j = 0; j < 4; j++) cs = cs ^ img[i][8*j +: 8];
      send_word(img[i], gaps);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (gaps) idle_gap();
    send(bad_csum ? (cs ^ 8'h01) : cs);
`else
    if (bad_csum) cs = cs ^ 8'h01;
`endif
  endtask

  task automatic expect_run(input string tag);
    @(negedge clock);
    check({tag, "_drain_done"}, 32'(done), 32'd0);
    check({tag, "_drain_cpurst"}, 32'(cpuReset), 32'd1);
    @(negedge clock);
    check({tag, "_run_done"}, 32'(done), 32'd1);
    check({tag, "_run_cpurst"}, 32'(cpuReset), 32'd0);
    check({tag, "_run_ready"}, 32'(byteReady), 32'd0);
  endtask

  task automatic expect_err(input string tag);
    @(negedge clock);
    check({tag, "_error"}, 32'(error), 32'd1);
    check({tag, "_ready"}, 32'(byteReady), 32'd0);
    check({tag, "_cpurst"}, 32'(cpuReset), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_en"}, 32'(insMemEn), 32'd0);
    check({tag, "_addr"}, insMemAddr, 32'd0);
    check({tag, "_data"}, insMemDataIn, 32'd0);
    check({tag, "_cpurst"}, 32'(cpuReset), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_ready"}, 32'(byteReady), 32'd1);
  endtask

  // A byte offered alongside reset must not be consumed
  task automatic do_reset(input string tag);
    reset     = 1'b1;
    byteValid = 1'b1;
    byteData  = 8'h55;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    byteValid = 1'b0;
    @(negedge clock);
    check_reset_vals(tag);
  endtask

  initial begin
    repeat (20000) @(posedge clock);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    byteValid = 1'b0;
    byteData  = 8'h00;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("por");

    // Two-word program, gap-free
    img = '{32'h0000_0013, 32'h0010_0093};
    load_img(1'b0, 1'b0);
    expect_run("two_word");

    // Empty image: no writes, straight to completion
    do_reset("rst_a");
    img = '{};
    load_img(1'b0, 1'b0);
    expect_run("empty");

    // Oversized word count
    do_reset("rst_b");
    send(8'h01); send(8'h02); send(8'h00); send(8'h00);
    expect_err("oversize");
    byteValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byteData = 8'(i);
      @(posedge clock);
    end
    #1;
    byteValid = 1'b0;
    @(negedge clock);
    check("oversize_hold_error", 32'(error), 32'd1);
    check("oversize_hold_cpurst", 32'(cpuReset), 32'd1);

    // One word whose bytes XOR to zero
    do_reset("rst_c");
    img = '{32'hDDCC_BBAA};
    load_img(1'b0, 1'b0);
    expect_run("csum_ok");
`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset("rst_d");
    load_img(1'b0, 1'b1);
    expect_err("csum_bad");
`endif

    // Three words with random valid gaps
    do_reset("rst_e");
    img = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C};
    load_img(1'b1, 1'b0);
    expect_run("gappy");

    // Reset after six payload bytes, then reload a one-word image
    do_reset("rst_f");
    send_word(32'd3, 1'b0);
    push_exp(32'd0, 32'h1122_3344);
    send_word(32'h1122_3344, 1'b0);
    send(8'hA1); send(8'hA2);
    do_reset("mid_load");
    img = '{32'hCAFE_F00D};
    load_img(1'b0, 1'b0);
    expect_run("reload");

    repeat (3) @(negedge clock);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot loader that streams a program into the processor's instruction memory through its write port (`insMemEn`, `insMemAddr`, `insMemDataIn`). It is the writer side of that port. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes them at consecutive word indices, holding the core in reset until the image is complete. It sits between the host link (UART RX or testbench) and the `processor` instance.

## Interface
- `WIDTH`, 32, word width; must be 32.
- `IMEM_DEPTH`, 512, instruction memory depth in words; maximum accepted word count.
- `clock`  input  1  sole clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high; returns the block to header reception.
- `byteValid`  input  1  `byteData` holds a valid byte.
- `byteData`  input  8  stream byte.
- `byteReady`  output  1  loader accepts a byte; a byte transfers on a cycle with `byteValid & byteReady`.
- `insMemEn`  output  1  instruction-memory write strobe; one-cycle pulse per word.
- `insMemAddr`  output  WIDTH  word index, not a byte address; 0, 1, 2, ….
- `insMemDataIn`  output  WIDTH  word to write.
- `cpuReset`  output  1  drives the processor `reset`; high until the load completes.
- `done`  output  1  load complete; the core is running.
- `error`  output  1  load rejected; sticky until `reset`.

## Operation
- States: HDR, DATA, [CHK], DRAIN, RUN, ERR. The reset state is HDR.
- `byteReady` is combinational: 1 in HDR, DATA and CHK; 0 in DRAIN, RUN and ERR.
- HDR: accepts 4 bytes as the little-endian word count N. The first byte is bits [7:0].
  - N > IMEM_DEPTH: go to ERR.
  - N == 0: go to CHK, or to DRAIN when the checksum is compiled out.
  - Otherwise go to DATA.
- DATA: a 2-bit byte lane counter packs bytes little-endian into a shift register.
  - On the 4th byte of word k: register `insMemDataIn` = word and `insMemAddr` = k, and pulse `insMemEn` on the next cycle.
  - Then increment k and clear the lane counter.
  - After word N-1 is packed, go to CHK or DRAIN.
- CHK: accepts one byte and compares it with the running XOR of all payload bytes. The header is excluded.
  - Match: go to DRAIN.
  - Mismatch: go to ERR.
- DRAIN: lasts one cycle, so the final write lands before the core leaves reset. Then go to RUN.
- RUN: `cpuReset` = 0, `done` = 1. Terminal state until `reset`.
- ERR: `error` = 1, `cpuReset` = 1, no further writes. Terminal state until `reset`.
- `insMemEn` is never asserted outside the cycle after a completed word. Partial trailing bytes are never written.
- Bytes presented while `byteReady` = 0 are neither consumed nor counted.
- Word count and index arithmetic are 32-bit unsigned. k never exceeds N-1, so there is no wrap.

## Timing
- Reset values:
  - `insMemEn` = 0, `insMemAddr` = 0, `insMemDataIn` = 0.
  - `cpuReset` = 1, `done` = 0, `error` = 0.
  - `byteReady` = 1; lane counter, k and checksum = 0.
- Write latency: 4th byte of a word accepted at cycle t -> `insMemEn` = 1 with valid address and data at t+1 only.
- Back-to-back: one byte per cycle is sustained. The next word's bytes are accepted during the write pulse.
- Completion, no checksum: last byte at t -> final write at t+1 (DRAIN) -> RUN at t+2 with `cpuReset` = 0 and `done` = 1.
- Completion with checksum: checksum byte at t -> DRAIN at t+1 -> RUN at t+2.
- Error: 4th header byte or bad checksum accepted at t -> `error` = 1 and `byteReady` = 0 at t+1.
- `reset` asserted mid-load: next cycle all outputs take their reset values. Words already written stay in memory. A new header is expected.
- `reset` and `byteValid` in the same cycle: reset wins and the byte is not consumed.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN`
  - Defined: CHK state present; a trailing XOR checksum byte is required; a mismatch leads to ERR.
  - Undefined: no CHK state. Completion occurs after the last payload byte, and `error` is raised only for N > IMEM_DEPTH.

## Test plan
- Stream header 02 00 00 00, then 13 00 00 00, then 93 00 10 00.
  - Required: `insMemEn` pulses writing idx0 = 0x00000013 and idx1 = 0x00100093.
  - Required: `done` = 1 and `cpuReset` = 0 exactly 2 cycles after the last byte.
- Header 00 00 00 00 with checksum disabled -> no `insMemEn` pulse; RUN 2 cycles after the 4th byte.
- Header 01 02 00 00 (N = 513 > 512) -> `error` = 1, `byteReady` = 0; subsequent bytes are ignored and `cpuReset` stays 1.
- With `IMEM_LOADER_CHECKSUM_EN`, one word AA BB CC DD:
  - Checksum byte 0x00 -> RUN.
  - Checksum byte 0x01 -> ERR.
  - The word is written in both cases.
- Random `byteValid` gaps across a 3-word load -> same writes and addresses as the gap-free case; no double-consumed bytes.
- Assert `reset` after 6 payload bytes, then reload a 1-word image -> first write goes to idx 0 with the new word; `done` follows.
